// File: rtl/vol_meter_display.sv
// vol_meter_display: segmented vertical volume bar renderer for the OLED pixel mux.
// Samples the level once per frame, smooths it (instant attack, timed release),
// tracks an optional peak-hold marker and renders registered RGB565 pixels.
// Optional feature macro: VOL_PEAK_HOLD_EN (peak registers, hold counter, white marker).
module vol_meter_display #(
  parameter int WIDTH        = 96,
  parameter int HEIGHT       = 64,
  parameter int SEGS         = 15,
  parameter int LVL_W        = 4,
  parameter int SEG_PITCH    = 4,
  parameter int BAR_X0       = 40,
  parameter int BAR_W        = 16,
  parameter int GREEN_SEGS   = 5,
  parameter int YELLOW_SEGS  = 5,
  parameter int DECAY_FRAMES = 4,
  parameter int HOLD_FRAMES  = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LVL_W-1:0] level,
  input  logic             freeze,
  input  logic [1:0]       border_mode,
  input  logic [12:0]      pixel_index,
  output logic [15:0]      oled_data,
  output logic [LVL_W-1:0] disp_level,
  output logic [LVL_W-1:0] peak_level
);

  localparam int DC_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  logic             prev_zero;
  logic             pix_zero;
  logic             upd;
  logic [LVL_W-1:0] lvl_sat;
  logic [DC_W-1:0]  dcnt;
  logic [DC_W-1:0]  dcnt_nxt;
  logic [LVL_W-1:0] disp_nxt;
  logic             marker_en;

  assign pix_zero = (pixel_index == 13'd0);
  // State only moves on the first cycle of a zero run, and never while frozen.
  assign upd      = pix_zero && !prev_zero && !freeze;
  assign lvl_sat  = (level > LVL_W'(SEGS)) ? LVL_W'(SEGS) : level;

  // Attack jumps straight up; release steps down one segment every DECAY_FRAMES ticks.
  always_comb begin
    disp_nxt = disp_level;
    dcnt_nxt = dcnt;
    if (lvl_sat >= disp_level) begin
      disp_nxt = lvl_sat;
      dcnt_nxt = '0;
    end else if (dcnt == DC_W'(DECAY_FRAMES - 1)) begin
      disp_nxt = disp_level - LVL_W'(1);
      dcnt_nxt = '0;
    end else begin
      dcnt_nxt = dcnt + DC_W'(1);
    end
  end

  // Frame-tick edge detector and smoothed level register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_zero  <= 1'b0;
      disp_level <= '0;
      dcnt       <= '0;
    end else begin
      prev_zero <= pix_zero;
      if (upd) begin
        disp_level <= disp_nxt;
        dcnt       <= dcnt_nxt;
      end
    end
  end

`ifdef VOL_PEAK_HOLD_EN
  localparam int HC_W = $clog2(HOLD_FRAMES + 1);
  logic [LVL_W-1:0] peak_q;
  logic [HC_W-1:0]  hcnt;

  // Peak follows the new displayed level upward, holds, then falls one step per tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_q <= '0;
      hcnt   <= '0;
    end else if (upd) begin
      if (disp_nxt >= peak_q) begin
        peak_q <= disp_nxt;
        hcnt   <= HC_W'(HOLD_FRAMES);
      end else if (hcnt != '0) begin
        hcnt <= hcnt - HC_W'(1);
      end else begin
        peak_q <= peak_q - LVL_W'(1);
      end
    end
  end

  assign peak_level = peak_q;
  assign marker_en  = (peak_q > disp_level);
`else
  assign peak_level = disp_level;
  assign marker_en  = 1'b0;
`endif

  logic [12:0] px_x, px_y, row_r, seg_k, bw;
  logic        on_screen, border, gap_row, in_bar, is_marker;
  logic [15:0] pix_nxt;

  assign px_x      = pixel_index % 13'(WIDTH);
  assign px_y      = pixel_index / 13'(WIDTH);
  assign on_screen = (pixel_index < 13'(WIDTH * HEIGHT));
  assign row_r     = 13'(HEIGHT - 1) - px_y;
  assign seg_k     = row_r / 13'(SEG_PITCH);
  assign gap_row   = ((row_r % 13'(SEG_PITCH)) == 13'(SEG_PITCH - 1));
  assign in_bar    = (px_x >= 13'(BAR_X0)) && (px_x < 13'(BAR_X0 + BAR_W)) &&
                     !gap_row && (seg_k < 13'(SEGS));
  // marker_en implies peak_level >= 1, so the subtraction cannot wrap when it matters.
  assign is_marker = marker_en && (seg_k == (13'(peak_level) - 13'd1));

  // Border width lookup and border hit test.
  always_comb begin
    case (border_mode)
      2'd0:    bw = 13'd0;
      2'd1:    bw = 13'd1;
      2'd2:    bw = 13'd3;
      default: bw = 13'd5;
    endcase
    border = (px_x < bw) || (px_x >= 13'(WIDTH) - bw) ||
             (px_y < bw) || (px_y >= 13'(HEIGHT) - bw);
  end

  // Colour priority: border, peak marker, lit segment by zone, black.
  always_comb begin
    pix_nxt = 16'h0000;
    if (!on_screen) begin
      pix_nxt = 16'h0000;
    end else if (border) begin
      pix_nxt = 16'hFFFF;
    end else if (in_bar && is_marker) begin
      pix_nxt = 16'hFFFF;
    end else if (in_bar && (seg_k < 13'(disp_level))) begin
      if (seg_k < 13'(GREEN_SEGS))                    pix_nxt = 16'h07E0;
      else if (seg_k < 13'(GREEN_SEGS + YELLOW_SEGS)) pix_nxt = 16'hFFE0;
      else                                            pix_nxt = 16'hF800;
    end
  end

  // One-cycle registered pixel output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) oled_data <= 16'h0000;
    else       oled_data <= pix_nxt;
  end

endmodule

// File: tb/tb_vol_meter_display.sv
module tb_vol_meter_display;

`ifdef VOL_PEAK_HOLD_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  level;
  logic        freeze;
  logic [1:0]  border_mode;
  logic [12:0] pixel_index;
  logic [15:0] oled_data;
  logic [3:0]  disp_level;
  logic [3:0]  peak_level;

  int n_pass = 0;
  int n_total = 0;

  vol_meter_display dut (
    .clk(clk), .reset(reset), .level(level), .freeze(freeze),
    .border_mode(border_mode), .pixel_index(pixel_index),
    .oled_data(oled_data), .disp_level(disp_level), .peak_level(peak_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present a pixel and wait until its registered colour is on oled_data.
  task automatic pix(input logic [12:0] p);
    @(negedge clk); pixel_index = p;
    @(negedge clk);
  endtask

  // One frame tick: a single cycle at pixel 0, then move off it.
  task automatic frame();
    @(negedge clk); pixel_index = 13'd0;
    @(negedge clk); pixel_index = 13'd1;
  endtask

  task automatic zrun();
    @(negedge clk); pixel_index = 13'd0;
    repeat (5) @(negedge clk);
    pixel_index = 13'd1;
  endtask

  initial begin
    reset = 1'b1; level = 4'd0; freeze = 1'b0; border_mode = 2'd0; pixel_index = 13'd1;
    repeat (3) @(negedge clk);
    chk("rst_oled", oled_data, 16'h0000);
    chk("rst_disp", disp_level, 16'd0);
    chk("rst_peak", peak_level, 16'd0);
    reset = 1'b0;

    level = 4'd9;
    frame();
    chk("l9_disp", disp_level, 16'd9);
    chk("l9_peak", peak_level, 16'd9);
    pix(13'd6088); chk("l9_green_k0", oled_data, 16'h07E0);
    pix(13'd3784); chk("l9_yellow_k6", oled_data, 16'hFFE0);
    pix(13'd2632); chk("l9_dark_k9", oled_data, 16'h0000);
    pix(13'd5800); chk("l9_gap_row", oled_data, 16'h0000);

    level = 4'd2;
    repeat (3) frame();
    chk("dec3_disp", disp_level, 16'd9);
    chk("dec3_peak", peak_level, 16'd9);
    frame();
    chk("dec4_disp", disp_level, 16'd8);
    chk("dec4_peak", peak_level, PK ? 16'd9 : 16'd8);
    pix(13'd3016); chk("dec4_marker", oled_data, PK ? 16'hFFFF : 16'h0000);
    repeat (23) frame();
    chk("dec27_disp", disp_level, 16'd3);
    frame();
    chk("dec28_disp", disp_level, 16'd2);
    chk("dec28_peak", peak_level, PK ? 16'd9 : 16'd2);
    repeat (5) frame();
    chk("dec33_peak", peak_level, PK ? 16'd9 : 16'd2);
    frame();
    chk("dec34_peak", peak_level, PK ? 16'd8 : 16'd2);
    repeat (6) frame();
    chk("dec40_peak", peak_level, 16'd2);
    repeat (4) frame();
    chk("dec44_disp_floor", disp_level, 16'd2);
    chk("dec44_peak_floor", peak_level, 16'd2);

    level = 4'd15;
    frame();
    chk("l15_disp", disp_level, 16'd15);
    chk("l15_peak", peak_level, 16'd15);
    pix(13'd712);  chk("l15_red_k14", oled_data, 16'hF800);
    pix(13'd2632); chk("l15_yellow_k9", oled_data, 16'hFFE0);
    pix(13'd480);  chk("bm0_edge_black", oled_data, 16'h0000);

    border_mode = 2'd2;
    pix(13'd0);    chk("bm2_0_0", oled_data, 16'hFFFF);
    pix(13'd962);  chk("bm2_2_10", oled_data, 16'hFFFF);
    pix(13'd2973); chk("bm2_93_30", oled_data, 16'hFFFF);
    pix(13'd5906); chk("bm2_50_61", oled_data, 16'hFFFF);
    pix(13'd291);  chk("bm2_3_3", oled_data, 16'h0000);
    pix(13'd6088); chk("bm2_over_bar", oled_data, 16'hFFFF);
    border_mode = 2'd1;
    pix(13'd480);  chk("bm1_0_5", oled_data, 16'hFFFF);
    pix(13'd97);   chk("bm1_1_1", oled_data, 16'h0000);
    border_mode = 2'd3;
    pix(13'd388);  chk("bm3_4_4", oled_data, 16'hFFFF);
    pix(13'd485);  chk("bm3_5_5", oled_data, 16'h0000);
    border_mode = 2'd0;
    chk("l15_disp_after_border", disp_level, 16'd15);

    level = 4'd2;
    repeat (2) frame();
    chk("pre_freeze_disp", disp_level, 16'd15);
    freeze = 1'b1;
    level = 4'd0;
    repeat (10) frame();
    chk("frz_disp", disp_level, 16'd15);
    chk("frz_peak", peak_level, 16'd15);
    freeze = 1'b0;
    frame();
    chk("unfrz1_disp", disp_level, 16'd15);
    frame();
    chk("unfrz2_disp", disp_level, 16'd14);
    chk("unfrz2_peak", peak_level, PK ? 16'd15 : 16'd14);

    repeat (3) zrun();
    chk("zrun3_disp", disp_level, 16'd14);
    zrun();
    chk("zrun4_disp", disp_level, 16'd13);

    pix(13'd6088); chk("pre_rst_green", oled_data, 16'h07E0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_oled", oled_data, 16'h0000);
    chk("mid_rst_disp", disp_level, 16'd0);
    chk("mid_rst_peak", peak_level, 16'd0);
    pixel_index = 13'd0;
    level = 4'd5;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("post_rst_tick", disp_level, 16'd5);
    chk("post_rst_peak", peak_level, 16'd5);
    level = 4'd9;
    repeat (2) @(negedge clk);
    chk("held_zero_once", disp_level, 16'd5);
    pixel_index = 13'd1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vol_meter_display.md
Name: vol_meter_display

Overview:
- Parametrised successor to the volume-bar OLED renderer.
- Takes a sampled microphone volume level and the OLED driver's pixel_index, and produces registered 16-bit RGB565 pixel data for a vertical segmented bar.
- Adds the following over the current renderer:
  - instant-attack / timed-release smoothing;
  - a peak-hold marker;
  - a freeze mode;
  - a selectable border width.
- Sits between the audio-level logic and the Oled_Display pixel mux.

Parameters:
- WIDTH, 96, screen width in pixels.
- HEIGHT, 64, screen height in pixels.
- SEGS, 15, number of bar segments (max level).
- LVL_W, 4, width of level inputs/outputs; must hold SEGS.
- SEG_PITCH, 4, rows per segment including gap; segment is SEG_PITCH-1 lit rows plus 1 gap row.
- BAR_X0, 40, leftmost bar column.
- BAR_W, 16, bar width in columns.
- GREEN_SEGS, 5, segments 0..GREEN_SEGS-1 are green.
- YELLOW_SEGS, 5, next YELLOW_SEGS segments are yellow; the rest are red.
- DECAY_FRAMES, 4, frames per 1-step fall of the displayed level.
- HOLD_FRAMES, 30, frames the peak is held before it decays.

Ports:
- clk  in  1  pixel clock, same domain as the pixel_index source.
- reset  in  1  asynchronous, active-high.
- level  in  LVL_W  raw volume level; values above SEGS saturate to SEGS.
- freeze  in  1  1 = hold all display state (no level sampling, no decay, no hold countdown).
- border_mode  in  2  border width: 0 = none, 1 = 1px, 2 = 3px, 3 = 5px.
- pixel_index  in  13  current pixel, row-major.
- oled_data  out  16  RGB565 for the pixel_index of the previous cycle.
- disp_level  out  LVL_W  currently displayed (smoothed) level.
- peak_level  out  LVL_W  current peak marker level.

Behaviour:
- Reset (async): oled_data=0, disp_level=0, peak_level=0, decay counter=0, hold counter=0, prev_zero=0.
- Frame tick: tick = (pixel_index==0) && !prev_zero. prev_zero registers (pixel_index==0) every cycle. Consequences:
  - the first 0 after reset fires a tick;
  - a pixel_index held at 0 fires exactly once.
- State updates happen only on tick && !freeze. With freeze=1, ticks are ignored and all counters hold.
- Level smoothing, with L = min(level, SEGS):
  - L >= disp_level: disp_level <= L, decay counter <= 0.
  - Otherwise, decay counter increments. When it reaches DECAY_FRAMES-1: disp_level decrements by 1 and the counter clears.
  - disp_level never drops below L (the decrement is bounded by L).
- Peak hold (evaluated with the new disp_level value d):
  - d >= peak_level: peak_level <= d, hold counter <= HOLD_FRAMES.
  - Else if hold counter != 0: decrement it.
  - Else: peak_level decrements by 1 per tick, never below d.
- Geometry: x = pixel_index % WIDTH, y = pixel_index / WIDTH.
  - pixel_index >= WIDTH*HEIGHT renders black.
  - r = HEIGHT-1-y; segment k = r / SEG_PITCH; gap row when r % SEG_PITCH == SEG_PITCH-1.
  - Rows with k >= SEGS are outside the bar.
- Colour priority, highest first:
  1. Border: x<bw, x>=WIDTH-bw, y<bw or y>=HEIGHT-bw, with bw from border_mode → white 16'hFFFF.
  2. In bar columns, non-gap row, k == peak_level-1, peak_level > disp_level → white.
  3. In bar columns, non-gap row, k < disp_level → green 16'h07E0 / yellow 16'hFFE0 / red 16'hF800 by zone.
  4. Otherwise black 16'h0000.
- Latency: oled_data is registered and valid 1 cycle after pixel_index. The render uses pre-update state in the tick cycle, so new state is visible from the pixel after index 0.
- Changes on border_mode or level are combinationally used on the next pixel or tick respectively; they need no synchronisation (same clock domain).
- Mid-frame reset: all state clears and oled_data=0 immediately. The next pixel_index==0 fires a tick.

Optional Feature:
- Macro: VOL_PEAK_HOLD_EN.
- Defined: peak-hold logic, hold counter and white peak marker exactly as above.
- Undefined:
  - no peak registers or hold counter;
  - peak_level is tied to disp_level;
  - the priority-2 marker rule is never true.

Test Plan:
- Reset then run frames with level=9, border_mode=0: after the first tick disp_level=9. Pixel (x=BAR_X0, y=63) → 16'h07E0; (BAR_X0, y=63-4*6) → 16'hFFE0; y=63-4*9 → 16'h0000; gap row y=60 → 16'h0000.
- Level 9 → 2 (DECAY_FRAMES=4): disp_level steps 9→8 after 4 ticks, reaching 2 after 28 ticks, never below 2. Peak_level stays 9 for 30 ticks, then falls by 1 per tick. Marker pixel at k=8 is 16'hFFFF while peak>disp.
- Level 15 (also level input 15 with SEGS=15 checked against saturation at SEGS): segment 14 pixel → 16'hF800; disp_level=15.
- border_mode=2, level=15: (0,0), (2,10), (93,30), (50,61) → 16'hFFFF; (3,3) → 16'h0000. Border overrides bar at (BAR_X0, 63).
- freeze=1 for 10 frames with level changing 9→0: disp_level/peak_level unchanged. Release freeze: decay resumes from the held counter value.
- Hold pixel_index=0 for 5 cycles, then assert reset mid-frame: exactly one tick per 0-run. Reset clears outputs to 0 asynchronously, before the next clk edge.
